pipelined_cs_adder: RTL and testbench
=====================================

Name: pipelined_cs_adder

Overview:
- Parametrised, pipelined carry-select adder/subtractor with valid/ready handshakes on both sides.
- The operand is split into NBLK = WIDTH/BLOCK slices.
  - All slice candidate sums (carry-in 0 and carry-in 1) are formed when the operation is accepted.
  - One slice is resolved per pipeline stage by carry selection.
- Used as the shared arithmetic unit for wide datapaths that need one result per clock at high frequency.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of BLOCK.
- BLOCK, 8, slice width in bits; 1 <= BLOCK <= WIDTH.

Ports:
- clk  in  1  rising-edge clock
- areset  in  1  asynchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in (add mode only)
- sub  in  1  0: a+b+cin; 1: a-b (cin ignored)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result
- cout  out  1  carry-out of MSB (sub mode: 1 = no borrow)
- ovf  out  1  signed two's-complement overflow

Behaviour:
- Clock/reset: one clock (clk). Reset is asynchronous and active-high (areset).
  - While areset is high, every pipeline valid bit and every data register clears to 0.
  - Hence out_valid=0, sum=0, cout=0, ovf=0 during reset.
  - in_ready is 1 whenever areset is low and the pipe is not stalled.
- Operand conditioning:
  - beff = sub ? ~b : b
  - c0 = sub ? 1 : cin
- Stage 1 (accept cycle):
  - For every slice k, compute s0[k], co0[k] (carry-in 0) and s1[k], co1[k] (carry-in 1) over a/beff bits [k*BLOCK +: BLOCK].
  - Resolve slice 0 using c0.
  - Register all candidates, resolved slice 0, its carry, and a/beff MSBs for the overflow check.
- Stage j (2..NBLK):
  - Select slice j-1 between its registered candidates using the carry registered from stage j-1.
  - Pass the new carry forward.
  - Slices already resolved pass through unchanged.
- Output:
  - The final stage register drives sum, cout and out_valid.
  - ovf = (a_msb == beff_msb) && (sum_msb != a_msb), computed in the last stage.
- Latency: exactly NBLK cycles from a beat accepted (in_valid && in_ready at edge) to out_valid high with no backpressure. If WIDTH==BLOCK, latency is 1.
- Throughput: one beat per cycle when out_ready is held high.
- Handshake and stall:
  - Global advance enable en = !out_valid || out_ready; in_ready = en.
  - When en=0, all stages hold (data and valid).
  - Bubbles are not squeezed: the stall is whole-pipe.
  - Beats are never dropped, duplicated or reordered.
  - in_valid=0 while en=1 inserts a bubble (valid=0) into stage 1.
  - Outputs are stable while out_valid && !out_ready.
- Arithmetic: modulo 2^WIDTH; no saturation. cout and ovf are reported per beat.
- Reset mid-operation: all in-flight beats are discarded. The first beat accepted after areset falls appears after NBLK cycles.
- Illegal parameters: WIDTH % BLOCK != 0 is a compile-time error (elaboration assertion).

Decomposition:
- Shared package pcsa_pkg:
  - NBLK function/localparam.
  - Stage record typedef (valid, per-slice s0/s1/co0/co1, resolved sum, carry, a_msb, b_msb).
- One natural sub-module, cs_slice:
  - Combinational BLOCK-bit slice producing s0, co0, s1, co1.
  - Instantiated NBLK times in stage 1.
- Selection and pipeline registers live in the top.

Test Plan (WIDTH=32, BLOCK=8, NBLK=4, out_ready=1 unless stated):
- add a=0x0000FFFF, b=0x00000001, cin=0 -> exactly 4 cycles later: out_valid=1, sum=0x00010000, cout=0, ovf=0 (carry ripples across slice boundaries 0->1->2).
- add a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1, ovf=0. Same operands with cin=1 -> sum=0x00000001, cout=1.
- sub a=0x80000000, b=0x00000001 -> sum=0x7FFFFFFF, cout=1, ovf=1. sub a=0x00000000, b=0x00000001 -> sum=0xFFFFFFFF, cout=0, ovf=0.
- add a=0x7FFFFFFF, b=0x00000001 -> sum=0x80000000, cout=0, ovf=1.
- Backpressure scenario:
  - Stimulus: stream 6 back-to-back beats (a=i, b=0x100*i, i=1..6); hold out_ready=0 for 3 cycles once the first result appears.
  - Required: in_ready=0 during the stall, held output stable, all 6 results emitted in order with correct sums, no extra out_valid pulses.
- Reset mid-flight:
  - Stimulus: accept 3 beats, assert areset asynchronously mid-cycle for 1 cycle.
  - Required: out_valid and sum go 0 immediately without waiting for a clock edge; no stale results ever emerge. A new beat accepted afterwards appears 4 cycles later.

Source files
------------

// File: rtl/pcsa_pkg.sv
//==============================================================================
// Module   : pcsa_pkg
// Purpose  : Shared sizing helpers for the pipelined carry-select adder.
// Revision : 1.0
//==============================================================================
`default_nettype none

package pcsa_pkg;

    localparam int C_DEF_WIDTH = 32;
    localparam int C_DEF_BLOCK = 8;

    // Number of slices, and therefore pipeline stages, for a given geometry.
    function automatic int nblk(input int width, input int block);
        return width / block;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipelined_cs_adder_slice.sv
//==============================================================================
// Module   : cs_slice
// Purpose  : Combinational slice forming both carry-select candidate sums.
// Revision : 1.0
//==============================================================================
`default_nettype none

module cs_slice
    import pcsa_pkg::*;
#(
    parameter int BLOCK = C_DEF_BLOCK
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    output logic [BLOCK-1:0] s0,
    output logic             co0,
    output logic [BLOCK-1:0] s1,
    output logic             co1
);

    assign {co0, s0} = {1'b0, a} + {1'b0, b};
    assign {co1, s1} = {1'b0, a} + {1'b0, b} + (BLOCK+1)'(1);

endmodule

`default_nettype wire

// File: rtl/pipelined_cs_adder.sv
//==============================================================================
// Module   : pipelined_cs_adder
// Purpose  : Pipelined carry-select adder/subtractor, one slice resolved per
//            stage, whole-pipe stall on output backpressure.
// Revision : 1.0
//==============================================================================
`default_nettype none

module pipelined_cs_adder
    import pcsa_pkg::*;
#(
    parameter int WIDTH = C_DEF_WIDTH,
    parameter int BLOCK = C_DEF_BLOCK
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NBLK = nblk(WIDTH, BLOCK);

    if ((BLOCK < 1) || (BLOCK > WIDTH) || ((WIDTH % BLOCK) != 0)) begin : g_bad_params
        $error("pipelined_cs_adder: WIDTH must be a positive multiple of BLOCK");
    end

    typedef struct packed {
        logic                       valid;
        logic [NBLK-1:0][BLOCK-1:0] s0;
        logic [NBLK-1:0][BLOCK-1:0] s1;
        logic [NBLK-1:0]            co0;
        logic [NBLK-1:0]            co1;
        logic [WIDTH-1:0]           sum;
        logic                       carry;
        logic                       a_msb;
        logic                       b_msb;
    } stage_t;

    stage_t                     r_st   [NBLK];
    stage_t                     w_next [NBLK];
    logic                       w_en;
    logic [WIDTH-1:0]           w_beff;
    logic                       w_c0;
    logic [NBLK-1:0][BLOCK-1:0] w_s0;
    logic [NBLK-1:0][BLOCK-1:0] w_s1;
    logic [NBLK-1:0]            w_co0;
    logic [NBLK-1:0]            w_co1;

    assign w_en     = !r_st[NBLK-1].valid || out_ready;
    assign in_ready = w_en && !areset;
    assign w_beff   = sub ? ~b : b;
    assign w_c0     = sub ? 1'b1 : cin;

    for (genvar k = 0; k < NBLK; k++) begin : g_slice
        cs_slice #(
            .BLOCK (BLOCK)
        ) u_slice (
            .a   (a[k*BLOCK +: BLOCK]),
            .b   (w_beff[k*BLOCK +: BLOCK]),
            .s0  (w_s0[k]),
            .co0 (w_co0[k]),
            .s1  (w_s1[k]),
            .co1 (w_co1[k])
        );
    end

    // Stage 0 captures every candidate and resolves slice 0; stage j resolves
    // slice j from the carry handed forward by stage j-1.
    always_comb begin
        for (int j = 0; j < NBLK; j++) begin
            w_next[j] = '0;
        end
        w_next[0].valid            = in_valid;
        w_next[0].s0               = w_s0;
        w_next[0].s1               = w_s1;
        w_next[0].co0              = w_co0;
        w_next[0].co1              = w_co1;
        w_next[0].sum[BLOCK-1:0]   = w_c0 ? w_s1[0] : w_s0[0];
        w_next[0].carry            = w_c0 ? w_co1[0] : w_co0[0];
        w_next[0].a_msb            = a[WIDTH-1];
        w_next[0].b_msb            = w_beff[WIDTH-1];
        for (int j = 1; j < NBLK; j++) begin
            w_next[j] = r_st[j-1];
            w_next[j].sum[j*BLOCK +: BLOCK] = r_st[j-1].carry ? r_st[j-1].s1[j]
                                                              : r_st[j-1].s0[j];
            w_next[j].carry = r_st[j-1].carry ? r_st[j-1].co1[j] : r_st[j-1].co0[j];
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            for (int j = 0; j < NBLK; j++) begin
                r_st[j] <= '0;
            end
        end else if (w_en) begin
            for (int j = 0; j < NBLK; j++) begin
                r_st[j] <= w_next[j];
            end
        end
    end

    assign out_valid = r_st[NBLK-1].valid;
    assign sum       = r_st[NBLK-1].sum;
    assign cout      = r_st[NBLK-1].carry;
    assign ovf       = (r_st[NBLK-1].a_msb == r_st[NBLK-1].b_msb)
                    && (r_st[NBLK-1].sum[WIDTH-1] != r_st[NBLK-1].a_msb);

endmodule

`default_nettype wire

// File: tb/tb_pipelined_cs_adder.sv
//==============================================================================
// Module   : tb_pipelined_cs_adder
// Purpose  : Scoreboard bench for pipelined_cs_adder (WIDTH=32, BLOCK=8).
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_pipelined_cs_adder;

    localparam int WIDTH = 32;
    localparam int BLOCK = 8;
    localparam int NBLK  = WIDTH / BLOCK;

    logic             clk       = 1'b0;
    logic             areset    = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a         = '0;
    logic [WIDTH-1:0] b         = '0;
    logic             cin       = 1'b0;
    logic             sub       = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    pipelined_cs_adder #(
        .WIDTH (WIDTH),
        .BLOCK (BLOCK)
    ) dut (
        .clk       (clk),
        .areset    (areset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        int               acc;
        bit               lat;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: samples after the driver has settled each falling edge.
    logic             held = 1'b0;
    logic [WIDTH-1:0] h_sum;
    logic             h_cout;
    logic             h_ovf;

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (out_valid) begin
            if (held) begin
                chk("hold_sum", sum, h_sum);
                chk("hold_cout", cout, h_cout);
                chk("hold_ovf", ovf, h_ovf);
            end else if (q.size() == 0) begin
                chk("unexpected_out_valid", out_valid, 1'b0);
            end else begin
                e = q[0];
                chk("sum", sum, e.sum);
                chk("cout", cout, e.cout);
                chk("ovf", ovf, e.ovf);
                if (e.lat) chk("latency", cyc + 1 - e.acc, NBLK);
            end
            if (!out_ready) begin
                chk("in_ready_stall", in_ready, 1'b0);
                held   = 1'b1;
                h_sum  = sum;
                h_cout = cout;
                h_ovf  = ovf;
            end else begin
                held = 1'b0;
                if (q.size() > 0) void'(q.pop_front());
            end
        end else begin
            held = 1'b0;
        end
    end

    task automatic drive(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_b,
                         input logic tcin, input logic tsub,
                         input logic [WIDTH-1:0] es, input logic ec, input logic eo,
                         input bit lat);
        exp_t e;
        int   k;
        @(negedge clk);
        a        = ta;
        b        = tb_b;
        cin      = tcin;
        sub      = tsub;
        in_valid = 1'b1;
        #1;
        k = 0;
        while (!in_ready && k < 100) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (!in_ready) begin
            chk("accept_timeout", in_ready, 1'b1);
        end else begin
            e.sum  = es;
            e.cout = ec;
            e.ovf  = eo;
            e.acc  = cyc + 1;
            e.lat  = lat;
            q.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() > 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (q.size() > 0) chk("drain_timeout", q.size(), 0);
    endtask

    initial begin
        #1 areset = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_sum", sum, '0);
        chk("rst_cout", cout, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3 areset = 1'b0;

        // Directed vectors, back to back at full throughput.
        drive(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b1);
        drive(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
        drive(32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 32'h00000001, 1'b1, 1'b0, 1'b1);
        drive(32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b1);
        drive(32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1);
        drive(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b1);
        drive(32'h00000005, 32'h00000003, 1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0, 1'b1);
        drive(32'h00FF00FF, 32'h00010001, 1'b1, 1'b0, 32'h01000101, 1'b0, 1'b0, 1'b1);
        idle();
        drain();

        // Backpressure: 3-cycle stall once the first stream result shows up.
        fork
            begin
                int k;
                k = 0;
                do begin
                    @(negedge clk);
                    k++;
                end while (!out_valid && k < 100);
                if (!out_valid) chk("bp_wait_timeout", out_valid, 1'b1);
                out_ready = 1'b0;
                repeat (3) @(negedge clk);
                out_ready = 1'b1;
            end
            begin
                for (int i = 1; i <= 6; i++) begin
                    drive(WIDTH'(i), WIDTH'(32'h100 * i), 1'b0, 1'b0,
                          WIDTH'(32'h101 * i), 1'b0, 1'b0, i == 1);
                end
                idle();
            end
        join
        drain();

        // Reset mid-flight: three beats in, first one sitting on the output.
        drive(32'h11111111, 32'h22222222, 1'b0, 1'b0, 32'h33333333, 1'b0, 1'b0, 1'b0);
        drive(32'h01010101, 32'h01010101, 1'b0, 1'b0, 32'h02020202, 1'b0, 1'b0, 1'b0);
        drive(32'h0000000A, 32'h00000001, 1'b0, 1'b1, 32'h00000009, 1'b1, 1'b0, 1'b0);
        idle();
        @(posedge clk);
        #3;
        chk("pre_reset_out_valid", out_valid, 1'b1);
        areset = 1'b1;
        #1;
        chk("async_rst_out_valid", out_valid, 1'b0);
        chk("async_rst_sum", sum, '0);
        q.delete();
        @(posedge clk);
        #3 areset = 1'b0;

        drive(32'h12345678, 32'h11111111, 1'b0, 1'b1, 32'h01234567, 1'b1, 1'b0, 1'b1);
        idle();
        drain();
        repeat (6) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
